// File: rtl/cla_result_fifo_pkg.sv
// Shared constants for the carry-look-ahead result FIFO.
// Optional feature macro: CLA_RESULT_PARITY_EN (adds a stored parity bit per entry).
package cla_result_fifo_pkg;

  // Defaults matching the adder instance this FIFO sits behind.
  localparam int unsigned CLA_WIDTH  = 7;
  localparam int unsigned CLA_DEPTH  = 4;
  localparam int unsigned CLA_DROP_W = 8;

`ifdef CLA_RESULT_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Stored entry is {parity?, carry, sum}.
  function automatic int unsigned entry_width(input int unsigned sum_w);
    return sum_w + 1 + PARITY_BITS;
  endfunction

endpackage

// File: rtl/cla_result_fifo_mem.sv
// DEPTH x ENTRY_W register array for cla_result_fifo.
// Ports: clk_i; write port wr_en_i/wr_addr_i/wr_data_i; combinational read rd_addr_i -> rd_data_o.
// Power pins vccd1/vssd1 present only when GL_TEST is defined.
// Contents are intentionally not reset.
module cla_result_fifo_mem #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 8,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
`ifdef GL_TEST
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cla_result_fifo.sv
// Capture FIFO for carry-look-ahead adder results {carry, sum}.
// A slower consumer drains entries with valid/ready; results offered while full are
// counted in a saturating drop counter.
// Ports:
//   clk, rst_n (async active-low)
//   in_valid/in_sum/in_carry -> in_ready (= !full)
//   out_valid (= !empty), out_ready, out_sum/out_carry/out_parity (show-ahead, 0 when empty)
//   level (occupancy 0..DEPTH), drop_cnt (saturating)
// Optional macro: CLA_RESULT_PARITY_EN stores ^{carry,sum} per entry and drives out_parity;
// otherwise out_parity is tied 0. GL_TEST adds vccd1/vssd1 power pins.
module cla_result_fifo
  import cla_result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = CLA_WIDTH,
  parameter int unsigned DEPTH  = CLA_DEPTH,
  parameter int unsigned DROP_W = CLA_DROP_W
) (
`ifdef GL_TEST
  inout  wire                       vccd1,
  inout  wire                       vssd1,
`endif
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_sum,
  input  logic                      in_carry,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_sum,
  output logic                      out_carry,
  output logic                      out_parity,
  output logic [$clog2(DEPTH):0]    level,
  output logic [DROP_W-1:0]         drop_cnt
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned ENTRY_W = entry_width(WIDTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               empty, full, push, pop;
  logic [ENTRY_W-1:0] wr_data, rd_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

`ifdef CLA_RESULT_PARITY_EN
  assign wr_data = {^{in_carry, in_sum}, in_carry, in_sum};
`else
  assign wr_data = {in_carry, in_sum};
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A rejected result bumps the counter, which sticks at all-ones.
    if (in_valid && full && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cla_result_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .AW      (AW)
  ) u_mem (
`ifdef GL_TEST
    .vccd1     (vccd1),
    .vssd1     (vssd1),
`endif
    .clk_i     (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // Flags and level depend on registered pointers only.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign drop_cnt  = drop_cnt_q;

  // Show-ahead head, forced to zero when nothing is stored.
  assign out_sum   = empty ? '0 : rd_data[WIDTH-1:0];
  assign out_carry = empty ? 1'b0 : rd_data[WIDTH];
`ifdef CLA_RESULT_PARITY_EN
  assign out_parity = empty ? 1'b0 : rd_data[WIDTH+1];
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_cla_result_fifo.sv
module tb_cla_result_fifo;

  localparam int W  = 7;
  localparam int D  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_sum = '0;
  logic          in_carry = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, out_carry, out_parity;
  logic [W-1:0]  out_sum;
  logic [2:0]    level;
  logic [DW-1:0] drop_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference: a plain queue of {carry,sum} plus a drop tally.
  logic [W:0]    mq[$];
  int unsigned   m_drops = 0;
  bit            m_push, m_pop, m_empty;
  logic [W:0]    m_head;
  logic          m_par;

  cla_result_fifo #(
    .WIDTH  (W),
    .DEPTH  (D),
    .DROP_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .out_parity (out_parity),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model update on each active edge using the inputs the DUT saw.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_drops = 0;
    end else begin
      m_pop  = out_ready && (mq.size() != 0);
      m_push = in_valid && (mq.size() < D);
      if (in_valid && (mq.size() == D) && (m_drops < 255)) m_drops++;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({in_carry, in_sum});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      m_empty = (mq.size() == 0);
      m_head  = m_empty ? '0 : mq[0];
`ifdef CLA_RESULT_PARITY_EN
      m_par   = m_empty ? 1'b0 : ^m_head;
`else
      m_par   = 1'b0;
`endif
      chk("in_ready",   32'(in_ready),   32'(mq.size() < D));
      chk("out_valid",  32'(out_valid),  32'(!m_empty));
      chk("level",      32'(level),      32'(mq.size()));
      chk("drop_cnt",   32'(drop_cnt),   32'(m_drops));
      chk("out_sum",    32'(out_sum),    32'(m_head[W-1:0]));
      chk("out_carry",  32'(out_carry),  32'(m_head[W]));
      chk("out_parity", 32'(out_parity), 32'(m_par));
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [W-1:0] s, input bit c, input bit r);
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // Reset mid-stream with three entries held and two drops counted.
    for (int i = 0; i < 6; i++) step(1'b1, 7'(i + 1), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t1_level", 32'(level), 32'd3);
    chk("t1_drop", 32'(drop_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_level", 32'(level), 32'd0);
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_sum", 32'(out_sum), 32'd0);
    chk("t1_async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    chk("t1_drop_after", 32'(drop_cnt), 32'd0);

    // Ordered capture of two results.
    step(1'b1, 7'h55, 1'b1, 1'b0);
    step(1'b1, 7'h2A, 1'b0, 1'b0);
    chk("t2_level", 32'(level), 32'd2);
    chk("t2_head0_sum", 32'(out_sum), 32'h55);
    chk("t2_head0_c", 32'(out_carry), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t2_head1_sum", 32'(out_sum), 32'h2A);
    chk("t2_head1_c", 32'(out_carry), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_empty_sum", 32'(out_sum), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Ten offers into a four-deep FIFO with no consumer.
    for (int i = 0; i < 10; i++) step(1'b1, 7'(8'h10 + i), 1'b1, 1'b0);
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_drop", 32'(drop_cnt), 32'd6);
    chk("t3_head", 32'(out_sum), 32'h10);

    // Full with simultaneous offer and pop.
    step(1'b1, 7'h7E, 1'b0, 1'b1);
    chk("t4_level", 32'(level), 32'd3);
    chk("t4_drop", 32'(drop_cnt), 32'd7);
    chk("t4_head", 32'(out_sum), 32'h11);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);

    // Drop counter saturation.
    pulse_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 7'($urandom), 1'($urandom), 1'b0);
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
    chk("t5_level", 32'(level), 32'd4);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // Push and pop together across pointer wrap.
    step(1'b1, 7'h7F, 1'b1, 1'b0);
`ifdef CLA_RESULT_PARITY_EN
    chk("t6_par_7f", 32'(out_parity), 32'd0);
`endif
    for (int i = 0; i < 2 * D + 3; i++) begin
      if (i == 0) step(1'b1, 7'h01, 1'b0, 1'b1);
      else step(1'b1, 7'($urandom), 1'($urandom), 1'b1);
      chk("t6_level", 32'(level), 32'd1);
`ifdef CLA_RESULT_PARITY_EN
      if (i == 0) chk("t6_par_01", 32'(out_parity), 32'd1);
`endif
    end
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t6_drained", 32'(out_valid), 32'd0);

    // Randomized traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) pulse_reset();
      step($urandom_range(0, 3) != 0, 7'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end
    step(1'b0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
